btn_cmd_ctrl: RTL

- Front-end command stage that sits directly upstream of counter_top and drives its cnt_start, cnt_stop and cnt_rst inputs.
- Takes three raw, asynchronous, bouncing push-button inputs and synchronises and debounces each one.
- Converts each debounced press into a single-cycle, arbitrated command pulse, so the counter sees at most one clean command per clock.

---
 rtl/btn_cmd_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/btn_cmd_ctrl.sv
// Push-button front end for counter_top: sync, debounce, press-edge detect, arbitration.
// Define BTN_LONGPRESS_RST_EN to turn a long stop hold into one extra cnt_rst command.
module btn_cmd_ctrl #(
  parameter logic [15:0] DB_CYCLES      = 16'd50000,
  parameter logic        BTN_ACTIVE_LOW = 1'b0,
  parameter logic [23:0] LONG_CYCLES    = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_raw,
  input  logic       btn_stop_raw,
  input  logic       btn_rst_raw,
  output logic       cnt_start,
  output logic       cnt_stop,
  output logic       cnt_rst,
  output logic [2:0] btn_level
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 16'd1);

  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    w_norm;
  logic [CW-1:0] r_db_cnt [3];
  logic [2:0]    r_level;
  logic [2:0]    r_level_d;
  logic [2:0]    w_press;
  logic [2:0]    w_cmd;
  logic [2:0]    r_cmd;
  logic          w_long_evt;

  // Channel order everywhere is {rst, stop, start}.
  assign w_raw   = {btn_rst_raw, btn_stop_raw, btn_start_raw};
  assign w_norm  = r_sync2 ^ {3{BTN_ACTIVE_LOW}};
  assign w_press = r_level & ~r_level_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= {3{BTN_ACTIVE_LOW}};
      r_sync2   <= {3{BTN_ACTIVE_LOW}};
      r_level   <= 3'b000;
      r_level_d <= 3'b000;
      r_cmd     <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_cmd     <= w_cmd;
      // Any cycle agreeing with the current level restarts the stability count.
      for (int i = 0; i < 3; i++) begin
        if (w_norm[i] != r_level[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_level[i]  <= ~r_level[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef BTN_LONGPRESS_RST_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CYCLES - 24'd1);

  logic [LW-1:0] r_long_cnt;
  logic          r_long_fired;

  // Event fires in the cycle the counter steps onto LONG_MAX, so the pulse lands on that edge.
  assign w_long_evt = r_level[1] & ~r_long_fired & (r_long_cnt == LONG_PRE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_long_cnt   <= '0;
      r_long_fired <= 1'b0;
    end else if (!r_level[1]) begin
      r_long_cnt   <= '0;
      r_long_fired <= 1'b0;
    end else begin
      if (r_long_cnt != LONG_MAX) begin
        r_long_cnt <= r_long_cnt + 1'b1;
      end
      if (w_long_evt) begin
        r_long_fired <= 1'b1;
      end
    end
  end
`else
  logic w_unused_long;
  assign w_unused_long = ^LONG_CYCLES;
  assign w_long_evt    = 1'b0;
`endif

  // Same-cycle events: rst > stop > start; losers are dropped.
  always_comb begin
    w_cmd = 3'b000;
    if (w_press[2] || w_long_evt) begin
      w_cmd = 3'b100;
    end else if (w_press[1]) begin
      w_cmd = 3'b010;
    end else if (w_press[0]) begin
      w_cmd = 3'b001;
    end
  end

  assign cnt_start = r_cmd[0];
  assign cnt_stop  = r_cmd[1];
  assign cnt_rst   = r_cmd[2];
  assign btn_level = r_level;

endmodule
